// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer read side.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  // Control bits that travel alongside the RAM read; hs/vs are active-high here.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } ctrl_t;

endpackage

// File: rtl/vga_framebuffer_reader_if.sv
// Frame-buffer read port plus VGA connector pins.
interface vga_framebuffer_reader_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [3:0]        vga_r;
  logic [3:0]        vga_g;
  logic [3:0]        vga_b;
  logic              vga_hs;
  logic              vga_vs;
  logic              frame_start;

  modport master (
    output rd_addr,
    input  rd_data,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );

endinterface

// File: rtl/vga_axis_timer.sv
// One VGA axis: position counter plus ACTIVE/FRONT/SYNC/BACK state machine.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FP_LEN     = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BP_LEN     = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       active,
  output logic       sync,
  output logic       wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [9:0] LAST_ACT  = 10'(ACTIVE_LEN - 1);
  localparam logic [9:0] LAST_FP   = 10'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [9:0] LAST_SYNC = 10'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [9:0] LAST      = 10'(TOTAL - 1);

  axis_state_t state, state_next;

  assign wrap   = en && (cnt == LAST);
  assign active = (state == ACTIVE);
  assign sync   = (state == SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (en) cnt <= wrap ? 10'd0 : cnt + 10'd1;
    end
  end

  // State leaves each region on its last count so it lines up with cnt.
  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        ACTIVE:  if (cnt == LAST_ACT)  state_next = FRONT;
        FRONT:   if (cnt == LAST_FP)   state_next = SYNC;
        SYNC:    if (cnt == LAST_SYNC) state_next = BACK;
        BACK:    if (cnt == LAST)      state_next = ACTIVE;
        default: state_next = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// VGA timing, linear frame-buffer address walk, and pin stage aligned to RAM latency.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int RD_LATENCY = 1
) (
  input logic                      pclk,
  input logic                      rst,
  vga_framebuffer_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [9:0] h_cnt, v_cnt;
  logic       h_active, h_sync, h_wrap;
  logic       v_active, v_sync, v_wrap;
  logic       pix_active;

  vga_axis_timer #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_timer (
    .clk    (pclk),
    .rst    (rst),
    .en     (1'b1),
    .cnt    (h_cnt),
    .active (h_active),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_timer (
    .clk    (pclk),
    .rst    (rst),
    .en     (h_wrap),
    .cnt    (v_cnt),
    .active (v_active),
    .sync   (v_sync),
    .wrap   (v_wrap)
  );

  assign pix_active = h_active && v_active;

  // Stage p0: address walk; addr always names the pixel at the current (h_cnt, v_cnt).
  logic [ADDR_W-1:0] addr_p0;

  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_p0 <= '0;
    end else if (h_wrap && v_wrap) begin
      addr_p0 <= '0;
    end else if (pix_active && (addr_p0 != ADDR_MAX)) begin
      addr_p0 <= addr_p0 + 1'b1;
    end
  end

  assign bus.rd_addr = addr_p0;

  ctrl_t ctrl_in;

  always_comb begin
    ctrl_in     = '0;
    ctrl_in.act = pix_active;
    ctrl_in.hs  = h_sync;
    ctrl_in.vs  = v_sync;
    ctrl_in.fs  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Stage p1: control delay matching the RAM; the last entry lines up with rd_data.
  ctrl_t ctrl_p1 [RD_LATENCY];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) ctrl_p1[i] <= '0;
    end else begin
      ctrl_p1[0] <= ctrl_in;
      for (int i = 1; i < RD_LATENCY; i++) ctrl_p1[i] <= ctrl_p1[i-1];
    end
  end

  ctrl_t ctrl_last;
  assign ctrl_last = ctrl_p1[RD_LATENCY-1];

  // Stage p2: pin registers; colour is masked here so blanking data never reaches the pins.
  logic [PIX_W-1:0] pix_p2;
  logic             hs_p2, vs_p2, fs_p2;

  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_p2 <= '0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      fs_p2  <= 1'b0;
    end else begin
      pix_p2 <= ctrl_last.act ? bus.rd_data : '0;
      hs_p2  <= ~ctrl_last.hs;
      vs_p2  <= ~ctrl_last.vs;
      fs_p2  <= ctrl_last.fs;
    end
  end

  assign bus.vga_r       = pix_p2[11:8];
  assign bus.vga_g       = pix_p2[7:4];
  assign bus.vga_b       = pix_p2[3:0];
  assign bus.vga_hs      = hs_p2;
  assign bus.vga_vs      = vs_p2;
  assign bus.frame_start = fs_p2;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench: default-timing readers at latency 1 and 2, plus a shrunken-timing reader for frame-level behaviour.
module tb_vga_framebuffer_reader;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_a = 1'b1;
  logic rst_s = 1'b1;
  int   key   = 0;

  int n_cmp = 0;
  int n_bad = 0;

  vga_framebuffer_reader_if ifa ();
  vga_framebuffer_reader_if ifb ();
  vga_framebuffer_reader_if ifs ();

  vga_framebuffer_reader #(.RD_LATENCY(1)) dut_a (.pclk(pclk), .rst(rst_a), .bus(ifa));
  vga_framebuffer_reader #(.RD_LATENCY(2)) dut_b (.pclk(pclk), .rst(rst_a), .bus(ifb));
  vga_framebuffer_reader #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .RD_LATENCY(2)
  ) dut_s (.pclk(pclk), .rst(rst_s), .bus(ifs));

  function automatic logic [11:0] dat(int a);
    return 12'((a * 37) ^ key);
  endfunction

  // RAM models: content is a keyed hash of the address.
  logic [11:0] ra1 = '0, rb1 = '0, rb2 = '0, rs1 = '0, rs2 = '0;
  always @(posedge pclk) begin
    ra1 <= dat(int'(ifa.rd_addr));
    rb1 <= dat(int'(ifb.rd_addr));
    rb2 <= rb1;
    rs1 <= dat(int'(ifs.rd_addr));
    rs2 <= rs1;
  end
  assign ifa.rd_data = ra1;
  assign ifb.rd_data = rb2;
  assign ifs.rd_data = rs2;

  wire [33:0] obs_a = {ifa.rd_addr, ifa.vga_r, ifa.vga_g, ifa.vga_b, ifa.vga_hs, ifa.vga_vs, ifa.frame_start};
  wire [33:0] obs_b = {ifb.rd_addr, ifb.vga_r, ifb.vga_g, ifb.vga_b, ifb.vga_hs, ifb.vga_vs, ifb.frame_start};
  wire [33:0] obs_s = {ifs.rd_addr, ifs.vga_r, ifs.vga_g, ifs.vga_b, ifs.vga_hs, ifs.vga_vs, ifs.frame_start};

  localparam logic [33:0] RST_PACK = {19'd0, 12'd0, 1'b1, 1'b1, 1'b0};

  // Expected {rd_addr, colour, hs, vs, fs} n cycles after reset release, from raster arithmetic.
  function automatic logic [33:0] model(int n, int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb, int lat);
    int ht, vt, h, v, m, hm, vm, amax, a;
    logic [11:0] col;
    logic hs, vs, fs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    amax = ha * va - 1;
    h = n % ht;
    v = (n / ht) % vt;
    if (v >= va) a = amax;
    else begin
      a = v * ha + ((h < ha) ? h : ha);
      if (a > amax) a = amax;
    end
    m = n - lat - 1;
    col = '0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
    if (m >= 0) begin
      hm = m % ht;
      vm = (m / ht) % vt;
      if (hm < ha && vm < va) col = dat(vm * ha + hm);
      hs = !(hm >= ha + hf && hm < ha + hf + hsw);
      vs = !(vm >= va + vf && vm < va + vf + vsw);
      fs = (hm == 0 && vm == 0);
    end
    return {19'(a), col, hs, vs, fs};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int addr;
    logic hs;
    logic fs;
    int pix;
  } vec_t;

  vec_t tbl [15];

  int n_a = 0, n_s = 0;
  int hs_fall_a = -1, hs_len_a = -1, hs_fall_b = -1, hs_len_b = -1;
  int vs_fall_s = -1, vs_len_s = -1, fs1_s = -1, fs2_s = -1;
  logic ph_a = 1'b1, ph_b = 1'b1, pv_s = 1'b1;

  initial begin
    int ra_at, rs1_at, rs1_len, rs2_at, rs2_len;
    logic [11:0] ecol;

    key = int'($urandom);
    ra_at   = 2200 + int'($urandom_range(0, 300));
    rs1_at  = 700  + int'($urandom_range(0, 400));
    rs1_len = 1    + int'($urandom_range(0, 2));
    rs2_at  = 1300 + int'($urandom_range(0, 400));
    rs2_len = 1    + int'($urandom_range(0, 2));

    tbl[0]  = '{0,    0,    1'b1, 1'b0, -1};
    tbl[1]  = '{1,    1,    1'b1, 1'b0, -1};
    tbl[2]  = '{2,    2,    1'b1, 1'b1, 0};
    tbl[3]  = '{3,    3,    1'b1, 1'b0, 1};
    tbl[4]  = '{641,  640,  1'b1, 1'b0, 639};
    tbl[5]  = '{642,  640,  1'b1, 1'b0, -1};
    tbl[6]  = '{657,  640,  1'b1, 1'b0, -1};
    tbl[7]  = '{658,  640,  1'b0, 1'b0, -1};
    tbl[8]  = '{753,  640,  1'b0, 1'b0, -1};
    tbl[9]  = '{754,  640,  1'b1, 1'b0, -1};
    tbl[10] = '{800,  640,  1'b1, 1'b0, -1};
    tbl[11] = '{801,  641,  1'b1, 1'b0, -1};
    tbl[12] = '{802,  642,  1'b1, 1'b0, 640};
    tbl[13] = '{1441, 1280, 1'b1, 1'b0, 1279};
    tbl[14] = '{1600, 1280, 1'b1, 1'b0, -1};

    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("reset_a", obs_a, RST_PACK);
      chk("reset_b", obs_b, RST_PACK);
      chk("reset_s", obs_s, RST_PACK);
    end
    rst_a = 1'b0;
    rst_s = 1'b0;

    for (int i = 0; i < 3200; i++) begin
      @(negedge pclk);
      if (rst_a) begin
        chk("rst_vals_a", obs_a, RST_PACK);
        chk("rst_vals_b", obs_b, RST_PACK);
      end
      if (rst_s) chk("rst_vals_s", obs_s, RST_PACK);
      n_a = rst_a ? 0 : n_a + 1;
      n_s = rst_s ? 0 : n_s + 1;

      chk("model_a", obs_a, model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1));
      chk("model_b", obs_b, model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      chk("model_s", obs_s, model(n_s, 12, 2, 3, 3, 6, 1, 2, 2, 2));

      for (int t = 0; t < 15; t++) begin
        if (tbl[t].cyc == n_a) begin
          ecol = (tbl[t].pix < 0) ? 12'd0 : dat(tbl[t].pix);
          chk("tbl_addr", 64'(ifa.rd_addr), 64'(tbl[t].addr));
          chk("tbl_hs", 64'(ifa.vga_hs), 64'(tbl[t].hs));
          chk("tbl_fs", 64'(ifa.frame_start), 64'(tbl[t].fs));
          chk("tbl_col", 64'({ifa.vga_r, ifa.vga_g, ifa.vga_b}), 64'(ecol));
        end
      end

      if (n_s == 111) chk("s_last_addr", 64'(ifs.rd_addr), 64'd71);
      if (n_s == 220) chk("s_wrap_addr", 64'(ifs.rd_addr), 64'd0);

      if (ph_a && !ifa.vga_hs && hs_fall_a < 0) hs_fall_a = n_a;
      if (!ph_a && ifa.vga_hs && hs_fall_a >= 0 && hs_len_a < 0) hs_len_a = n_a - hs_fall_a;
      if (ph_b && !ifb.vga_hs && hs_fall_b < 0) hs_fall_b = n_a;
      if (!ph_b && ifb.vga_hs && hs_fall_b >= 0 && hs_len_b < 0) hs_len_b = n_a - hs_fall_b;
      if (pv_s && !ifs.vga_vs && vs_fall_s < 0) vs_fall_s = n_s;
      if (!pv_s && ifs.vga_vs && vs_fall_s >= 0 && vs_len_s < 0) vs_len_s = n_s - vs_fall_s;
      if (ifs.frame_start) begin
        if (fs1_s < 0) fs1_s = n_s;
        else if (fs2_s < 0) fs2_s = n_s;
      end
      ph_a = ifa.vga_hs;
      ph_b = ifb.vga_hs;
      pv_s = ifs.vga_vs;

      rst_a = (i == ra_at);
      rst_s = (i >= rs1_at && i < rs1_at + rs1_len) || (i >= rs2_at && i < rs2_at + rs2_len);
    end

    chk("hs_fall_a", 64'(hs_fall_a), 64'd658);
    chk("hs_len_a", 64'(hs_len_a), 64'd96);
    chk("hs_fall_b", 64'(hs_fall_b), 64'd659);
    chk("hs_len_b", 64'(hs_len_b), 64'd96);
    chk("vs_fall_s", 64'(vs_fall_s), 64'd143);
    chk("vs_len_s", 64'(vs_len_s), 64'd40);
    chk("fs_first_s", 64'(fs1_s), 64'd3);
    chk("fs_period_s", 64'(fs2_s - fs1_s), 64'd220);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer_reader.md
# vga_framebuffer_reader

Read side of the camera frame buffer. Generates 640x480@60 VGA timing from a 25 MHz pixel clock. Fetches one RGB444 word per active pixel from the read port of the dual-port frame-buffer RAM, whose write port is fed by the OV7670 capture path. Drives the VGA connector pins with sync and colour aligned through the RAM read pipeline.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `RD_LATENCY`, 1, RAM read latency in cycles (1 or 2)

Ports (clocking: one clock; reset is synchronous and active-high; clock port `pclk`, reset port `rst`):
- `pclk` in 1: 25 MHz pixel clock, all logic on rising edge
- `rst` in 1: synchronous active-high reset
- `rd_addr` out 19: frame-buffer read address
- `rd_data` in 12: RAM read data, {R[3:0],G[3:0],B[3:0]}, valid `RD_LATENCY` cycles after `rd_addr`
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour, forced 0 outside the active area
- `vga_hs` out 1: horizontal sync, active low
- `vga_vs` out 1: vertical sync, active low
- `frame_start` out 1: one-cycle pulse aligned with output pixel (0,0)

## Operation
- Horizontal counter `h_cnt` runs 0..799 (sum of the H parameters minus 1), 10 bits.
- Vertical counter `v_cnt` runs 0..524, 10 bits. It increments only when `h_cnt` wraps 799->0.
- Each axis has a 4-state FSM, ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with transitions at the parameter boundaries. This state, not a re-comparison, drives blank and sync.
- Vertical FSM advances only on the horizontal wrap.
- Active pixel means both FSMs are in ACTIVE, i.e. h_cnt < 640 and v_cnt < 480.
- Sync generation:
  - hsync is asserted low for h_cnt 656..751.
  - vsync is asserted low for v_cnt 490..491, across whole lines.
- Address generation:
  - The address counter increments by 1 on every active-pixel cycle and holds otherwise.
  - It clears to 0 when h_cnt and v_cnt are both 0, so pixel (x,y) reads address y*640+x with no multiplier.
  - Maximum address is 307199. The counter never exceeds it and returns to 0 at the next frame start.
- `rd_addr` is driven every cycle. During blanking it holds its last value; the returned data is ignored.
- Output stage:
  - Colour is registered from `rd_data` when the delayed active flag is 1, otherwise 0.
  - Sync, active and `frame_start` pass through a delay line of length `RD_LATENCY`+1 so that they align with colour.

## Timing
- Reset values: `rd_addr`=0, `vga_r`/`vga_g`/`vga_b`=0, `vga_hs`=1, `vga_vs`=1, `frame_start`=0. Counters are at (0,0) and the delay line is flushed to blank/inactive.
- On the first cycle after `rst` deasserts, `rd_addr`=0 for pixel (0,0).
- Latency from `rd_addr` to colour pins is `RD_LATENCY`+1 cycles: 2 at default.
- `frame_start` pulses 2 cycles after the first post-reset cycle, then every 420000 cycles.
- Line period is 800 cycles; frame period is 525 lines.
- The hs falling edge on the pins occurs `RD_LATENCY`+1 cycles after h_cnt reaches 656.
- If `rst` is asserted mid-frame, the next cycle returns to the reset values. No partial pixel or sync glitch may emerge from the delay line.
- Simultaneous h-wrap and v-wrap (799,524 -> 0,0): the address clears in the same cycle. There is no stale increment.

## Structure
- Shared package `vga_pkg` holds:
  - the timing defaults (640/16/96/48, 480/10/2/33)
  - the axis-FSM state enum {ACTIVE, FRONT, SYNC, BACK}
  - the 19-bit address width and 12-bit pixel width constants
- One sub-module, `vga_axis_timer`: counter plus FSM, parameterised by active/fp/sync/bp, with a count-enable input and outputs cnt/active/sync/wrap. It is instantiated twice: horizontal with enable tied to 1, vertical with enable driven by the horizontal wrap.

## Test plan
- Reset check: hold `rst` for 5 cycles. Outputs must equal the reset values, then `rd_addr`=0,1,2… on consecutive cycles.
- Line timing: drive `rd_data`=rd_addr[11:0] through a 1-cycle RAM model.
  - Pixel x must show colour x[11:0] exactly 2 cycles after its address.
  - Colour must be 0 for the 160 blank cycles.
  - Line period must be 800 cycles.
- Sync positions: `vga_hs` is low for exactly 96 cycles starting at line cycle 658 (pin time). `vga_vs` is low for exactly 1600 cycles starting at line 490.
- Address extent:
  - Line 1 begins at `rd_addr`=640 and line 479 ends at 307199.
  - The next active cycle reads 0, and `frame_start` period is 420000.
- Mid-frame reset: assert `rst` at line 200, pixel 300. The next cycle must show reset values. The following frame must restart at address 0 with no out-of-place colour.
- `RD_LATENCY`=2 build: repeat the line-timing scenario with a 2-cycle RAM model. Colour and sync must be 3 cycles after the address.
